// File: rtl/sram_nibble_host.sv
// sram_nibble_host
// Host-side controller for the nibble-serial SRAM macro. Turns byte-wide
// write / read / stream / reset commands into SRAM pin ticks and returns
// read data on a single-entry valid/ready response register.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   cmd_valid/ready     command handshake
//   cmd_op              00 write, 01 read, 10 stream, 11 SRAM reset
//   cmd_addr            address for write/read
//   cmd_wdata           write byte
//   cmd_len             stream byte count, 0 means 2^AW
//   rsp_valid/ready     response handshake
//   rsp_data, rsp_last  returned byte, last byte of the command
//   sram_io_out         registered pins {nibble, oe, we, rst, sram_clk}
//   sram_io_in          SRAM data pins
//
// The pin map packs the AW-bit nibble into [7:4], so AW must be 4.
//
// state | meaning
// IDLE  | waiting for a command, pins 0x00
// RST_L | reset tick, SRAM clock low
// RST_H | reset tick, SRAM clock high
// WR_L  | write tick (nibble widx), clock low
// WR_H  | write tick, clock high
// RD_L  | read tick, clock low
// RD_H  | read tick, clock high
// ST_L  | stream tick, clock low
// ST_H  | stream tick, clock high
// CAP   | capture cycle, sram_io_in registered at its end
// RSP   | response held until accepted
module sram_nibble_host #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [AW-1:0] cmd_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic [7:0]    sram_io_out,
    input  logic [7:0]    sram_io_in
);

    typedef enum logic [3:0] {
        IDLE, RST_L, RST_H, WR_L, WR_H, RD_L, RD_H, ST_L, ST_H, CAP, RSP
    } state_t;

    localparam logic [1:0]  OP_WR = 2'b00;
    localparam logic [1:0]  OP_RD = 2'b01;
    localparam logic [1:0]  OP_ST = 2'b10;
    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    widx_q, widx_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          dirty_q, dirty_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_last_q, rsp_last_d;
    logic [6:0]    pin_hi_q, pin_hi_d;
    logic          pin_clk_q;
    logic [AW-1:0] nib_w;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_last    = rsp_last_q;
    assign sram_io_out = {pin_hi_q, pin_clk_q};

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        widx_d      = widx_q;
        cnt_d       = cnt_q;
        dirty_d     = dirty_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        cmd_ready   = (state_q == IDLE) && !rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    widx_d  = 2'd0;
                    cnt_d   = (cmd_len == '0) ? DEPTH : {1'b0, cmd_len};
                    case (cmd_op)
                        OP_WR:   state_d = dirty_q ? RST_L : WR_L;
                        OP_RD:   state_d = RD_L;
                        default: state_d = RST_L;
                    endcase
                end
            end
            RST_L: begin
                dirty_d = 1'b0;
                state_d = RST_H;
            end
            RST_H: begin
                case (op_q)
                    OP_WR:   state_d = WR_L;
                    OP_ST:   state_d = ST_L;
                    default: state_d = IDLE;
                endcase
            end
            WR_L: state_d = WR_H;
            WR_H: begin
                if (widx_q == 2'd2) begin
                    state_d = IDLE;
                end else begin
                    widx_d  = widx_q + 2'd1;
                    state_d = WR_L;
                end
            end
            RD_L: state_d = RD_H;
            RD_H: state_d = CAP;
            ST_L: begin
                // Stream ticks advance the SRAM counter, so later writes need a resync.
                dirty_d = 1'b1;
                state_d = ST_H;
            end
            ST_H: state_d = CAP;
            CAP: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = sram_io_in[DW-1:0];
                rsp_last_d  = (op_q != OP_ST) || (cnt_q == ONE);
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (op_q == OP_ST && cnt_q != ONE) begin
                        cnt_d   = cnt_q - ONE;
                        state_d = ST_L;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin bits [7:1] are computed from the next state so they land together
    // with the L state; H/CAP/RSP hold them and only the SRAM clock moves.
    always_comb begin
        case (widx_d)
            2'd0:    nib_w = wdata_d[AW-1:0];
            2'd1:    nib_w = wdata_d[DW-1:AW];
            default: nib_w = addr_d;
        endcase
        case (state_d)
            IDLE:    pin_hi_d = 7'd0;
            RST_L:   pin_hi_d = 7'b0000_001;
            WR_L:    pin_hi_d = {nib_w, 3'b010};
            RD_L:    pin_hi_d = {addr_d, 3'b100};
            ST_L:    pin_hi_d = 7'b0000_110;
            default: pin_hi_d = pin_hi_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            widx_q      <= 2'd0;
            cnt_q       <= '0;
            dirty_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            pin_hi_q    <= 7'd0;
            pin_clk_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            widx_q      <= widx_d;
            cnt_q       <= cnt_d;
            dirty_q     <= dirty_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            pin_hi_q    <= pin_hi_d;
            pin_clk_q   <= (state_d == RST_H) || (state_d == WR_H) ||
                           (state_d == RD_H)  || (state_d == ST_H);
        end
    end

endmodule

// File: tb/tb_sram_nibble_host.sv
// Testbench for sram_nibble_host: behavioural nibble SRAM on the pins,
// directed command sequence, response scoreboard.
module tb_sram_nibble_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_addr = 4'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic [3:0] cmd_len = 4'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic [7:0] sram_io_out;
    logic [7:0] sram_io_in = 8'd0;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb[$];      // {last, data}
    logic [7:0] pexp[$];
    logic [7:0] ref_mem[16];

    // SRAM model state
    logic [7:0] mem[16];
    logic [3:0] m_buf[3];
    int         m_widx = 0;
    logic [3:0] m_cnt = 4'd0;

    sram_nibble_host #(.AW(4), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .sram_io_out(sram_io_out), .sram_io_in(sram_io_in)
    );

    always #5 clk = ~clk;

    // Nibble SRAM: acts on the rising SRAM clock.
    always @(posedge sram_io_out[0]) begin
        if (sram_io_out[1]) begin
            m_cnt  = 4'd0;
            m_widx = 0;
        end else if (sram_io_out[2] && !sram_io_out[3]) begin
            m_buf[m_widx] = sram_io_out[7:4];
            if (m_widx == 2) begin
                mem[sram_io_out[7:4]] = {m_buf[1], m_buf[0]};
                m_widx = 0;
            end else begin
                m_widx++;
            end
        end else if (sram_io_out[3] && !sram_io_out[2]) begin
            sram_io_in = mem[sram_io_out[7:4]];
        end else if (sram_io_out[3] && sram_io_out[2]) begin
            sram_io_in = mem[m_cnt];
            m_cnt      = m_cnt + 4'd1;
            m_widx     = (m_widx == 2) ? 0 : m_widx + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] a,
                         input logic [7:0] d, input logic [3:0] l);
        int b;
        b = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (b >= 50) chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_len   = l;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_wdata = 8'($urandom);
        cmd_len   = 4'($urandom);
    endtask

    // Entered at T+1; checks pexp[i] at T+1+i. With rdy_chk, cmd_ready must
    // be low until the last entry and high on it.
    task automatic run_pins(input string tag, input bit rdy_chk);
        for (int i = 0; i < pexp.size(); i++) begin
            if (i > 0) @(negedge clk);
            chk(tag, {24'd0, sram_io_out}, {24'd0, pexp[i]});
            if (rdy_chk)
                chk({tag, "_rdy"}, {31'd0, cmd_ready}, (i == pexp.size() - 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic pop_cmp(input string tag);
        logic [8:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, {24'd0, rsp_data}, {24'd0, e[7:0]});
            chk({tag, "_last"}, {31'd0, rsp_last}, {31'd0, e[8]});
        end
    endtask

    task automatic do_write(input string tag, input logic [3:0] a, input logic [7:0] d, input bit dirty);
        ref_mem[a] = d;
        issue(2'b00, a, d, 4'd0);
        pexp = {};
        if (dirty) begin
            pexp.push_back(8'h02);
            pexp.push_back(8'h03);
        end
        pexp.push_back({d[3:0], 4'h4});
        pexp.push_back({d[3:0], 4'h5});
        pexp.push_back({d[7:4], 4'h4});
        pexp.push_back({d[7:4], 4'h5});
        pexp.push_back({a, 4'h4});
        pexp.push_back({a, 4'h5});
        pexp.push_back(8'h00);
        run_pins(tag, 1'b1);
    endtask

    task automatic do_read(input string tag, input logic [3:0] a);
        sb.push_back({1'b1, ref_mem[a]});
        issue(2'b01, a, 8'd0, 4'd0);
        pexp = '{{a, 4'h8}, {a, 4'h9}, {a, 4'h8}};
        run_pins(tag, 1'b0);
        chk({tag, "_vld_t3"}, {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_vld_t4"}, {31'd0, rsp_valid}, 32'd1);
        pop_cmp(tag);
        @(negedge clk);
        chk({tag, "_rdy_t5"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic collect(input int n, input int stall_idx);
        int got;
        int budget;
        got = 0;
        budget = 0;
        while (got < n && budget < 400) begin
            @(negedge clk);
            budget++;
            if (rsp_valid === 1'b1) begin
                if (got == stall_idx && sb.size() > 0) begin
                    rsp_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        @(negedge clk);
                        chk("stall_clk", {31'd0, sram_io_out[0]}, 32'd0);
                        chk("stall_data", {24'd0, rsp_data}, {24'd0, sb[0][7:0]});
                        chk("stall_vld", {31'd0, rsp_valid}, 32'd1);
                    end
                    rsp_ready = 1'b1;
                end
                pop_cmp("stream");
                got++;
            end
        end
        chk("stream_count", got, n);
        chk("stream_sb_left", sb.size(), 0);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            mem[k]     = 8'h80 + 8'(k);
            ref_mem[k] = 8'h80 + 8'(k);
        end

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_pins", {24'd0, sram_io_out}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);

        // Dirty write after reset, then clean back-to-back write
        do_write("wr_dirty", 4'd5, 8'hA7, 1'b1);
        do_write("wr_clean", 4'd6, 8'h3C, 1'b0);
        do_read("rd5", 4'd5);
        do_read("rd6", 4'd6);

        // SRAM reset op
        issue(2'b11, 4'd0, 8'd0, 4'd0);
        pexp = '{8'h02, 8'h03, 8'h00};
        run_pins("rst_op", 1'b1);

        // Stream len 4 with a 5-cycle stall on byte 1
        for (int k = 0; k < 4; k++) begin
            mem[k]     = 8'h10 + 8'(k);
            ref_mem[k] = 8'h10 + 8'(k);
        end
        for (int k = 0; k < 4; k++) sb.push_back({k == 3, ref_mem[k]});
        issue(2'b10, 4'd0, 8'd0, 4'd4);
        pexp = '{8'h02, 8'h03, 8'h0C, 8'h0D, 8'h0C};
        run_pins("st4_pins", 1'b0);
        collect(4, 1);

        // Stream len 0 covers all 16 locations, then a write must resync
        for (int k = 0; k < 16; k++) sb.push_back({k == 15, ref_mem[k]});
        issue(2'b10, 4'd0, 8'd0, 4'd0);
        collect(16, -1);
        do_write("wr_after_st", 4'd9, 8'h5A, 1'b1);
        do_read("rd9", 4'd9);

        // Reset during ST_H of byte 2
        for (int k = 0; k < 2; k++) sb.push_back({1'b0, ref_mem[k]});
        issue(2'b10, 4'd0, 8'd0, 4'd4);
        for (int c = 1; c < 12; c++) begin
            if (rsp_valid === 1'b1) pop_cmp("midrst");
            @(negedge clk);
        end
        chk("midrst_st_h", {24'd0, sram_io_out}, 32'h0D);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_pins", {24'd0, sram_io_out}, 32'd0);
        chk("midrst_vld", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_sb", sb.size(), 0);
        do_write("wr_after_rst", 4'd3, 8'h81, 1'b1);
        do_read("rd3", 4'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_nibble_host.md
# sram_nibble_host

- Host-side controller placed directly upstream of the nibble-serial SRAM macro.
- Accepts byte-wide write, read, stream and reset commands on a valid/ready interface.
- Converts each command into the SRAM pin protocol: 4-bit shared address/data nibble, oe, we, rst, and an SRAM clock generated from `clk`.
- Returns read data on a valid/ready response channel. Tracks the SRAM's internal nibble counter so that writes are never misaligned.

## Interface
- `AW`, 4, SRAM address width and nibble width.
- `DW`, 8, data width. Must equal 2*AW.
- `clk`  in  1  system clock.
- `rst`  in  1  reset: synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  command opcode:
  - 00 write.
  - 01 read.
  - 10 stream.
  - 11 SRAM reset.
- `cmd_addr`  in  AW  address for write and read.
- `cmd_wdata`  in  DW  write data.
- `cmd_len`  in  AW  stream byte count. 0 means DEPTH (2^AW).
- `rsp_valid`  out  1  read/stream byte available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_data`  out  DW  returned byte.
- `rsp_last`  out  1  final byte of the command. Always 1 for read.
- `sram_io_out`  out  8  drives the SRAM pins, registered:
  - [7:4] nibble.
  - [3] oe.
  - [2] we.
  - [1] rst.
  - [0] SRAM clock.
- `sram_io_in`  in  8  SRAM data pins.

## Operation
- **SRAM tick**: two system cycles, L then H.
  - L: bit0=0; nibble/oe/we/rst set to the tick values.
  - H: same values with bit0=1, which gives the SRAM its rising edge.
  - Pin bits [7:1] change only on entry to L.
- **Tick kinds**:
  - Reset tick: rst=1, oe=0, we=0, nibble=0.
  - Write tick: oe=0, we=1.
  - Read tick: oe=1, we=0, nibble=addr.
  - Stream tick: oe=1, we=1, nibble=0.
- **Capture**: every read or stream tick is followed by one capture cycle C.
  - Pins hold with bit0=0.
  - `sram_io_in` is registered into `rsp_data` at the end of C.
- **dirty flag**:
  - Reset value 1.
  - Set by any stream.
  - Cleared by any reset tick.
- **Write**:
  - If dirty, a reset tick runs first.
  - Then three write ticks with nibbles `cmd_wdata[3:0]`, `cmd_wdata[7:4]`, `cmd_addr`.
  - No response is generated.
- **Read**: one read tick, then C, then a response with `rsp_last=1`.
- **Stream**:
  - Always starts with a reset tick, so the SRAM counter is 0.
  - Then for k=0..len-1: stream tick, C, response byte mem[k].
  - `rsp_last=1` on byte len-1.
  - The SRAM counter wraps modulo DEPTH, so len=DEPTH covers the whole array.
  - Leaves dirty=1.
- **SRAM reset op**: one reset tick. No response.
- **FSM states**: IDLE, RST_L, RST_H, WR_L, WR_H, RD_L, RD_H, ST_L, ST_H, CAP, RSP.
  - A 2-bit nibble index counts the write ticks.
  - An AW+1-bit down-counter counts the remaining stream bytes.
- **Response register**: single entry, held stable while `rsp_valid & !rsp_ready`.
  - The next stream tick does not start until the current byte is accepted.
  - The SRAM clock stays low during that stall.
- `cmd_ready` is 1 only in IDLE with `rsp_valid=0`.
- **Idle pins**: `sram_io_out=0x00`.
- **Reset values**:
  - `sram_io_out=0x00`.
  - `cmd_ready=1` in the cycle after reset.
  - `rsp_valid=0`, `rsp_last=0`, `rsp_data=0`.
  - dirty=1.
  - State IDLE.
- **Reset mid-operation**:
  - The operation in progress is abandoned.
  - Pins return to 0x00 on the next cycle.
  - Any pending response is dropped.
  - dirty=1, so the next write or stream re-synchronises the SRAM.

## Timing
- Command handshake in cycle T.
- Write, clean: L/H pairs at T+1..T+6; IDLE with `cmd_ready=1` at T+7.
- Write, dirty: reset tick at T+1..T+2, so every later step is 2 cycles later (`cmd_ready=1` at T+9).
- Read: L T+1, H T+2, C T+3; `rsp_valid=1` at T+4.
  - `cmd_ready` returns the cycle after the response handshake.
- Stream: reset tick T+1..T+2; first byte L T+3, H T+4, C T+5; `rsp_valid` at T+6.
  - Each later byte's L starts the cycle after the previous response handshake.
  - With `rsp_ready` held high, the byte period is 4 cycles.
- SRAM reset op: T+1..T+2; `cmd_ready=1` at T+3.
- `cmd_*` inputs are sampled only at the handshake and are ignored afterwards.

## Test plan
- **Write after reset**: `rst`, then write addr 5 data 0xA7.
  - `sram_io_out` must go 0x02, 0x03, 0x74, 0x75, 0xA4, 0xA5, 0x54, 0x55, then 0x00.
  - `cmd_ready` must rise at T+9.
- **Read**: read addr 5 with the SRAM model holding 0xA7.
  - Pins must go 0x58, 0x59, 0x58.
  - `rsp_valid` at T+4 with `rsp_data=0xA7` and `rsp_last=1`.
- **Back-to-back clean write**: write addr 6 data 0x3C immediately after the write above.
  - No reset tick; first pin value 0xC4.
  - `cmd_ready` at T+7.
- **Stream with backpressure**: preload mem[0..3]=0x10..0x13, stream len 4, hold `rsp_ready=0` for 5 cycles on byte 1.
  - Bytes must be 0x10, 0x11, 0x12, 0x13, with `rsp_last` set only on 0x13.
  - Bit0 must stay 0 and `rsp_data` must stay stable during the stall.
- **Write after stream**: stream len 0 (16 bytes), then write.
  - A reset tick (0x02, 0x03) must precede the write nibbles.
- **Reset mid-stream**: assert `rst` during the ST_H of byte 2.
  - Next cycle: pins 0x00 and `rsp_valid=0`.
  - The following write must start with a reset tick.
